dmem_arbiter: RTL

Two-port arbiter and access sequencer placed in front of the single-port byte-addressed data memory. It shares the memory between two requesters: port 0 (CPU load/store stage) and port 1 (DMA/loader). Per-cycle arbitration is round-robin, with optional locked bursts bounded by a beat counter. Read data is registered and returned one cycle after grant.

---
 rtl/dmem_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between two requesters: round-robin per beat, with locked bursts capped at MAX_BURST.
// Grant has zero latency (combinational); load data follows one cycle after grant. A port that is not granted holds its request.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  p0_req_i,
    input  logic                  p0_lock_i,
    input  logic                  p0_we_i,
    input  logic                  p0_byte_op_i,
    input  logic [DATA_WIDTH-1:0] p0_addr_i,
    input  logic [DATA_WIDTH-1:0] p0_wd_i,
    output logic                  p0_gnt_o,
    output logic                  p0_rvalid_o,
    output logic [DATA_WIDTH-1:0] p0_rdata_o,

    input  logic                  p1_req_i,
    input  logic                  p1_lock_i,
    input  logic                  p1_we_i,
    input  logic                  p1_byte_op_i,
    input  logic [DATA_WIDTH-1:0] p1_addr_i,
    input  logic [DATA_WIDTH-1:0] p1_wd_i,
    output logic                  p1_gnt_o,
    output logic                  p1_rvalid_o,
    output logic [DATA_WIDTH-1:0] p1_rdata_o,

    output logic                  mem_we_o,
    output logic                  mem_byte_op_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wd_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_i,

    output logic [1:0]            owner_o
);

    localparam int              BW        = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]   BURST_MAX = BW'(MAX_BURST);
    // A one-beat burst limit makes every beat a forced release, so lock never takes ownership.
    localparam bit              LOCK_EN   = (MAX_BURST > 1);

    typedef struct packed {
        logic                  req;
        logic                  lock;
        logic                  we;
        logic                  byte_op;
        logic [DATA_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wd;
    } port_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    port_req_t [1:0] preq;
    state_t          state_q, state_d;
    logic            last_q, last_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [BW-1:0]   beat_inc;
    logic [1:0]      gnt;
    logic            sel;
    logic [1:0]      rvalid_q;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

    assign preq[0] = {p0_req_i, p0_lock_i, p0_we_i, p0_byte_op_i, p0_addr_i, p0_wd_i};
    assign preq[1] = {p1_req_i, p1_lock_i, p1_we_i, p1_byte_op_i, p1_addr_i, p1_wd_i};
    assign beat_inc = beat_q + BW'(1);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        beat_d  = beat_q;
        gnt     = 2'b00;
        sel     = 1'b0;

        case (state_q)
            IDLE: begin
                // Under contention the port that did not win last time goes first.
                if (preq[0].req && preq[1].req) sel = ~last_q;
                else                            sel = preq[1].req;

                if (preq[0].req || preq[1].req) begin
                    gnt[sel] = 1'b1;
                    last_d   = sel;
                    if (preq[sel].lock && LOCK_EN) begin
                        state_d = sel ? OWN1 : OWN0;
                        beat_d  = BW'(1);
                    end
                end
            end

            OWN0, OWN1: begin
                sel = (state_q == OWN1);
                if (preq[sel].req) begin
                    gnt[sel] = 1'b1;
                    beat_d   = beat_inc;
                    if (!preq[sel].lock || beat_inc == BURST_MAX) begin
                        state_d = IDLE;
                        beat_d  = '0;
                        last_d  = sel;
                    end
                end else begin
                    // Owner went quiet: give the memory back, costing one idle cycle.
                    state_d = IDLE;
                    beat_d  = '0;
                    last_d  = sel;
                end
            end

            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase

        if (rst_i) gnt = 2'b00;
    end

    always_comb begin
        mem_we_o      = 1'b0;
        mem_byte_op_o = 1'b0;
        mem_addr_o    = '0;
        mem_wd_o      = '0;
        if (gnt[0] || gnt[1]) begin
            mem_we_o      = preq[sel].we;
            mem_byte_op_o = preq[sel].byte_op;
            mem_addr_o    = preq[sel].addr;
            mem_wd_o      = preq[sel].wd;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rvalid_q[0] <= gnt[0] && !preq[0].we;
            rvalid_q[1] <= gnt[1] && !preq[1].we;
            if (gnt[0] && !preq[0].we) rdata0_q <= mem_rd_i;
            if (gnt[1] && !preq[1].we) rdata1_q <= mem_rd_i;
        end
    end

    assign p0_gnt_o    = gnt[0];
    assign p1_gnt_o    = gnt[1];
    assign p0_rvalid_o = rvalid_q[0];
    assign p1_rvalid_o = rvalid_q[1];
    assign p0_rdata_o  = rdata0_q;
    assign p1_rdata_o  = rdata1_q;
    assign owner_o     = {state_q != IDLE, state_q == OWN1};

endmodule
